fnd_scan_driver: RTL and testbench
==================================

Name: fnd_scan_driver

Overview:
- Downstream consumer of the 3-bit scan counter's `digit_sel` in the watch datapath.
- Converts the watch time fields (msec, sec, min, hour) into multiplexed active-low 7-segment drive: common-anode `fnd_com` plus `fnd_data`.
- Adds dead-time blanking on every scan step and a frame-synchronous snapshot of the time fields, so the display shows no ghosting or tearing.
- Includes a half-second blinking dot.

Parameters:
- DEAD_CYCLES, 4, clk cycles of forced blank after each `digit_sel` change (0 = none).
- SEL_WIDTH, 3, width of `digit_sel`. Fixed at 3; other values are unsupported.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- digit_sel  input  3  scan position from the scan counter; may change on any clk edge
- i_msec  input  7  0..99, centiseconds
- i_sec  input  6  0..59
- i_min  input  6  0..59
- i_hour  input  5  0..23
- sw_mode  input  1  0 = sec:msec view, 1 = hour:min view
- fnd_com  output  4  active-low digit enables; bit n drives digit n (digit 0 = rightmost)
- fnd_data  output  8  active-low segments {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset (async, active-high):
  - fnd_com=4'hF, fnd_data=8'hFF.
  - prev_sel=0, all snapshot registers=0, dead_cnt=DEAD_CYCLES, state=DEAD.
- Reset mid-frame blanks the outputs immediately, in the same cycle it is asserted.
- States:
  - DEAD: outputs are blank. dead_cnt decrements each clk. When dead_cnt reaches 0, the next cycle enters DRIVE.
  - DRIVE: outputs are decoded from registered prev_sel and the snapshot.
- Change detection:
  - Each clk, prev_sel <= digit_sel.
  - If digit_sel != prev_sel in any state: dead_cnt <= DEAD_CYCLES and state <= DEAD.
  - Outputs are blank in the following cycle; a change during DEAD restarts the count.
  - With DEAD_CYCLES=0, DEAD lasts exactly one cycle.
- Latency from a digit_sel change, with no further change, to drive: DEAD_CYCLES+2 clk.
- Snapshot:
  - When prev_sel==7 and digit_sel==0 (frame wrap), all four time fields and sw_mode are registered.
  - Between wraps, the displayed values are frozen.
- Digit split: tens = v/10, ones = v%10 on the snapshot values.
  - Out-of-range inputs (msec>99, sec/min>59, hour>23) are clamped to their maximum before the split.
- Digit phase, prev_sel[2]=0: position p = prev_sel[1:0]; fnd_com = ~(1<<p).
  - Mode 0: p0 = msec ones, p1 = msec tens, p2 = sec ones, p3 = sec tens.
  - Mode 1: p0 = min ones, p1 = min tens, p2 = hour ones, p3 = hour tens.
  - fnd_data = SEG[digit] with dp=1 (off).
- Dot phase, prev_sel[2]=1: fnd_com = ~(1<<p) as above.
  - fnd_data = 8'h7F only when p==2 and dot_on; otherwise 8'hFF.
  - dot_on = (snap_msec < 50) in both modes.
- Segment table: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90, blank FF.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: FND_LEADING_ZERO_BLANK_EN.
- When defined: in the digit phase, a tens digit at p3 or p1 equal to 0 drives 8'hFF instead of C0.
  - Mode 1, 05:07 displays " 5 7"; mode 0 is blanked the same way.
- When undefined: all zeros are displayed as C0.

Decomposition:
- Package fnd_pkg:
  - SEG_0..SEG_9, SEG_BLANK=8'hFF, SEG_DOT=8'h7F.
  - COM_OFF=4'hF.
  - Enum view_mode_t {VIEW_SEC_MSEC, VIEW_HOUR_MIN}.
  - Enum scan_state_t {DEAD, DRIVE}.
- One sub-module: fnd_seg_decoder, combinational, 4-bit BCD -> 8-bit active-low segment pattern. Values >9 map to SEG_BLANK.

Test Plan:
- Reset: assert reset mid-DRIVE with fnd_com=4'hE -> fnd_com=4'hF and fnd_data=8'hFF in the same cycle; after release, the outputs stay blank for DEAD_CYCLES+1 cycles.
- Mode 0 readout: msec=37, sec=42, frame wrap, then digit_sel held at 0,1,2,3 -> after settling, (fnd_com, fnd_data) = (E, F8), (D, B0), (B, A4), (7, 99).
- Dead time: step digit_sel 1->2 with DEAD_CYCLES=4 -> fnd_com=4'hF for exactly 5 cycles, then B/A4; a second step during DEAD restarts the blank count.
- Snapshot: change sec 42->43 mid-frame -> digits keep showing 42 until the 7->0 wrap, then show 43.
- Dot phase: digit_sel=6 with msec=20 -> B/7F; with msec=80 -> B/FF; digit_sel=5 -> D/FF.
- Mode 1 and macro: hour=5, min=7, digit_sel=3 -> 7/C0 without FND_LEADING_ZERO_BLANK_EN, 7/FF with it. An input of hour=30 is clamped and displays 23.

Source files
------------

// File: rtl/fnd_pkg.sv
// fnd_pkg: segment patterns, digit-enable constants and enums shared by the FND scan driver.
package fnd_pkg;
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DOT   = 8'h7F;
    localparam logic [3:0] COM_OFF   = 4'hF;

    typedef enum logic {VIEW_SEC_MSEC, VIEW_HOUR_MIN} view_mode_t;
    typedef enum logic {DEAD, DRIVE} scan_state_t;
endpackage

// File: rtl/fnd_seg_decoder.sv
// fnd_seg_decoder: 4-bit BCD to active-low {dp,g,f,e,d,c,b,a}; non-decimal codes blank.
module fnd_seg_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: multiplexed 4-digit common-anode drive with dead-time blanking and frame snapshot.
// Optional: FND_LEADING_ZERO_BLANK_EN blanks zero tens digits.
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int DEAD_CYCLES = 4,
    parameter int SEL_WIDTH   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SEL_WIDTH-1:0] digit_sel,
    input  logic [6:0]           i_msec,
    input  logic [5:0]           i_sec,
    input  logic [5:0]           i_min,
    input  logic [4:0]           i_hour,
    input  logic                 sw_mode,
    output logic [3:0]           fnd_com,
    output logic [7:0]           fnd_data
);
    localparam int CW = DEAD_CYCLES > 1 ? $clog2(DEAD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(DEAD_CYCLES);

    scan_state_t          state, state_nxt;
    logic [CW-1:0]        dead_cnt, cnt_nxt;
    logic [SEL_WIDTH-1:0] prev_sel;
    logic [6:0]           snap_msec;
    logic [5:0]           snap_sec, snap_min;
    logic [4:0]           snap_hour;
    view_mode_t           snap_mode;
    logic                 changed, wrap, lz_blank;
    logic [1:0]           p;
    logic [6:0]           val;
    logic [3:0]           tens, ones, digit;
    logic [7:0]           seg, data_nxt;
    logic [3:0]           com_nxt;

    fnd_seg_decoder u_dec (.bcd(digit), .seg(seg));

    always_comb begin
        changed   = digit_sel != prev_sel;
        wrap      = prev_sel == SEL_WIDTH'(7) && digit_sel == '0;
        state_nxt = changed ? DEAD : (state == DEAD && dead_cnt == '0) ? DRIVE : state;
        cnt_nxt   = changed ? CNT_INIT : (state == DEAD && dead_cnt != '0) ? dead_cnt - CW'(1) : dead_cnt;
        p         = prev_sel[1:0];
        // p0/p1 show the low field of the view, p2/p3 the high field
        val       = p[1] ? (snap_mode == VIEW_HOUR_MIN ? {2'b0, snap_hour} : {1'b0, snap_sec})
                         : (snap_mode == VIEW_HOUR_MIN ? {1'b0, snap_min} : snap_msec);
        tens      = 4'(val / 7'd10);
        ones      = 4'(val % 7'd10);
        digit     = p[0] ? tens : ones;
`ifdef FND_LEADING_ZERO_BLANK_EN
        lz_blank  = p[0] && tens == 4'd0;
`else
        lz_blank  = 1'b0;
`endif
        com_nxt   = state_nxt == DEAD ? COM_OFF : ~(4'b0001 << p);
        data_nxt  = state_nxt == DEAD ? SEG_BLANK
                  : prev_sel[2] ? ((p == 2'd2 && snap_msec < 7'd50) ? SEG_DOT : SEG_BLANK)
                  : lz_blank ? SEG_BLANK : seg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= DEAD;
            dead_cnt  <= CNT_INIT;
            prev_sel  <= '0;
            snap_msec <= '0;
            snap_sec  <= '0;
            snap_min  <= '0;
            snap_hour <= '0;
            snap_mode <= VIEW_SEC_MSEC;
            fnd_com   <= COM_OFF;
            fnd_data  <= SEG_BLANK;
        end else begin
            state    <= state_nxt;
            dead_cnt <= cnt_nxt;
            prev_sel <= digit_sel;
            fnd_com  <= com_nxt;
            fnd_data <= data_nxt;
            if (wrap) begin
                snap_msec <= i_msec > 7'd99 ? 7'd99 : i_msec;
                snap_sec  <= i_sec > 6'd59 ? 6'd59 : i_sec;
                snap_min  <= i_min > 6'd59 ? 6'd59 : i_min;
                snap_hour <= i_hour > 5'd23 ? 5'd23 : i_hour;
                snap_mode <= view_mode_t'(sw_mode);
            end
        end
    end
endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb_fnd_scan_driver: directed stimulus with a decimal-arithmetic display model checked every cycle.
module tb_fnd_scan_driver;
    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] digit_sel;
    logic [6:0] i_msec;
    logic [5:0] i_sec, i_min;
    logic [4:0] i_hour;
    logic       sw_mode;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    int total = 0;
    int bad = 0;

    fnd_scan_driver #(.DEAD_CYCLES(DC), .SEL_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .digit_sel(digit_sel),
        .i_msec(i_msec), .i_sec(i_sec), .i_min(i_min), .i_hour(i_hour),
        .sw_mode(sw_mode), .fnd_com(fnd_com), .fnd_data(fnd_data)
    );

    always #5 clk = ~clk;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // Model: edges since the last scan change (reset counts as one) plus a decimal snapshot.
    logic [2:0] m_prev;
    int since, s_msec, s_sec, s_min, s_hour, s_mode;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_prev <= 3'd0;
            since  <= 0;
            s_msec <= 0; s_sec <= 0; s_min <= 0; s_hour <= 0; s_mode <= 0;
        end else begin
            since  <= (digit_sel != m_prev) ? 0 : (since < 1000 ? since + 1 : since);
            m_prev <= digit_sel;
            if (m_prev == 3'd7 && digit_sel == 3'd0) begin
                s_msec <= (int'(i_msec) > 99) ? 99 : int'(i_msec);
                s_sec  <= (int'(i_sec) > 59) ? 59 : int'(i_sec);
                s_min  <= (int'(i_min) > 59) ? 59 : int'(i_min);
                s_hour <= (int'(i_hour) > 23) ? 23 : int'(i_hour);
                s_mode <= int'(sw_mode);
            end
        end
    end

    function automatic logic [11:0] model_out();
        int pos, field, d;
        logic [3:0] c;
        logic [7:0] dat;
        if (since <= DC) return {4'hF, 8'hFF};
        pos = int'(m_prev) % 4;
        c = ~(4'b0001 << pos);
        if (m_prev >= 3'd4) begin
            dat = (pos == 2 && s_msec < 50) ? 8'h7F : 8'hFF;
        end else begin
            field = (pos < 2) ? (s_mode == 1 ? s_min : s_msec) : (s_mode == 1 ? s_hour : s_sec);
            d = (pos % 2 == 1) ? field / 10 : field % 10;
            dat = seg_tab[d];
`ifdef FND_LEADING_ZERO_BLANK_EN
            if (pos % 2 == 1 && d == 0) dat = 8'hFF;
`endif
        end
        return {c, dat};
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got com=%h data=%h, want com=%h data=%h at %0t",
                     name, got[11:8], got[7:0], want[11:8], want[7:0], $time);
        end
    endtask

    task automatic expect_out(input string name, input logic [3:0] c, input logic [7:0] d);
        check(name, {fnd_com, fnd_data}, {c, d});
    endtask

    always @(negedge clk) check("model", {fnd_com, fnd_data}, model_out());

    task automatic show(input logic [2:0] sel, input logic [3:0] c, input logic [7:0] d, input string name);
        digit_sel = sel;
        repeat (DC + 2) @(negedge clk);
        expect_out(name, c, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; digit_sel = 3'd0; sw_mode = 1'b0;
        i_msec = 7'd0; i_sec = 6'd0; i_min = 6'd0; i_hour = 5'd0;
        repeat (3) @(negedge clk);
        expect_out("reset_state", 4'hF, 8'hFF);
        reset = 1'b0;
        repeat (DC) @(negedge clk);
        expect_out("post_reset_blank", 4'hF, 8'hFF);
        @(negedge clk);
        expect_out("post_reset_drive", 4'hE, 8'hC0);

        i_msec = 7'd37; i_sec = 6'd42;
        show(3'd7, 4'h7, 8'hFF, "pre_wrap_dot");
        show(3'd0, 4'hE, 8'hF8, "m0_p0");
        show(3'd1, 4'hD, 8'hB0, "m0_p1");
        show(3'd2, 4'hB, 8'hA4, "m0_p2");
        show(3'd3, 4'h7, 8'h99, "m0_p3");

        show(3'd1, 4'hD, 8'hB0, "dead_pre");
        digit_sel = 3'd2;
        for (int i = 0; i < DC + 1; i++) begin
            @(negedge clk);
            expect_out("dead_blank", 4'hF, 8'hFF);
        end
        @(negedge clk);
        expect_out("dead_drive", 4'hB, 8'hA4);
        digit_sel = 3'd1;
        repeat (3) @(negedge clk);
        digit_sel = 3'd2;
        for (int i = 0; i < DC + 1; i++) begin
            @(negedge clk);
            expect_out("dead_restart_blank", 4'hF, 8'hFF);
        end
        @(negedge clk);
        expect_out("dead_restart_drive", 4'hB, 8'hA4);

        i_sec = 6'd43;
        show(3'd3, 4'h7, 8'h99, "snap_frozen_p3");
        show(3'd2, 4'hB, 8'hA4, "snap_frozen_p2");
        show(3'd7, 4'h7, 8'hFF, "snap_p7");
        show(3'd0, 4'hE, 8'hF8, "snap_wrap_p0");
        show(3'd2, 4'hB, 8'hB0, "snap_new_p2");

        i_msec = 7'd20;
        show(3'd7, 4'h7, 8'hFF, "dot_p7");
        show(3'd0, 4'hE, 8'hC0, "dot_p0");
        show(3'd6, 4'hB, 8'h7F, "dot_on");
        i_msec = 7'd80;
        show(3'd7, 4'h7, 8'hFF, "dot_p7b");
        show(3'd0, 4'hE, 8'hC0, "dot_p0b");
        show(3'd6, 4'hB, 8'hFF, "dot_off");
        show(3'd5, 4'hD, 8'hFF, "dot_p5");

        sw_mode = 1'b1; i_hour = 5'd5; i_min = 6'd7;
        show(3'd7, 4'h7, 8'hFF, "m1_p7");
        show(3'd0, 4'hE, 8'hF8, "m1_p0");
`ifdef FND_LEADING_ZERO_BLANK_EN
        show(3'd3, 4'h7, 8'hFF, "m1_p3_lz");
`else
        show(3'd3, 4'h7, 8'hC0, "m1_p3_zero");
`endif
        show(3'd2, 4'hB, 8'h92, "m1_p2");
        i_hour = 5'd30;
        show(3'd7, 4'h7, 8'hFF, "clamp_p7");
        show(3'd0, 4'hE, 8'hF8, "clamp_p0");
        show(3'd3, 4'h7, 8'hA4, "clamp_p3");
        show(3'd2, 4'hB, 8'hB0, "clamp_p2");

        show(3'd0, 4'hE, 8'hF8, "pre_async");
        @(posedge clk);
        #3 reset = 1'b1;
        #1 expect_out("async_reset", 4'hF, 8'hFF);
        @(negedge clk);
        reset = 1'b0;
        repeat (DC) @(negedge clk);
        expect_out("async_blank", 4'hF, 8'hFF);
        @(negedge clk);
        expect_out("async_drive", 4'hE, 8'hC0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
